// File: rtl/fir_sample_source_pkg.sv
// Shared types and defaults for the FIR sample source.
//   src_state_e : playback FSM states (IDLE, RUN)
//   SRC_*       : default sample width, table depth, address width, strobe period
//   clamp_len   : maps a requested pass length onto 1..depth (0 or oversize -> depth)
package fir_src_pkg;

  localparam int SRC_DW     = 12;
  localparam int SRC_DEPTH  = 200;
  localparam int SRC_AW     = 8;
  localparam int SRC_PERIOD = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } src_state_e;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return (len == 0 || len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/fir_sample_source_if.sv
// Control/data bundle between a controller and the FIR sample source.
//   master : the sample source (drives en, xin, busy, done)
//   slave  : the controller side (drives table writes and playback control)
// Signals:
//   wr_en/wr_addr/wr_data : sample table write port
//   start/stop/len/loop   : playback control
//   en/xin                : one-cycle sample strobe and held sample word to the FIR
//   busy/done             : playback status
interface fir_sample_source_if
  import fir_src_pkg::*;
#(
  parameter int DW = SRC_DW,
  parameter int AW = SRC_AW
) ();

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          stop;
  logic [AW-1:0] len;
  logic          loop;
  logic          en;
  logic [DW-1:0] xin;
  logic          busy;
  logic          done;

  modport master (
    input  wr_en, wr_addr, wr_data, start, stop, len, loop,
    output en, xin, busy, done
  );

  modport slave (
    output wr_en, wr_addr, wr_data, start, stop, len, loop,
    input  en, xin, busy, done
  );

endinterface

// File: rtl/fir_sample_ram.sv
// Simple dual-port synchronous sample RAM, read-first.
//   clk             : rising-edge clock
//   rst             : synchronous active-high reset of the read data register only
//   wr_en/addr/data : write port; addresses >= DEPTH are dropped
//   rd_en/rd_addr   : read request; rd_data updates one clock later and holds otherwise
//   rd_data         : registered read data
module fir_sample_ram #(
  parameter int DW    = 12,
  parameter int DEPTH = 200,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Same-cycle write to rd_addr is not visible here: the old word is returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fir_sample_source.sv
// Plays a loadable sample table into a serial FIR as a one-cycle en strobe
// with a held xin word, one strobe every PERIOD clocks.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fir_sample_source_if master modport
//          (table writes, start/stop/len/loop in; en/xin/busy/done out)
// The table read register doubles as xin: it is loaded only at the read
// phase, so xin changes exactly when en rises and holds in between.
module fir_sample_source
  import fir_src_pkg::*;
#(
  parameter int DW     = SRC_DW,
  parameter int DEPTH  = SRC_DEPTH,
  parameter int AW     = SRC_AW,
  parameter int PERIOD = SRC_PERIOD
) (
  input  logic                clk,
  input  logic                rst,
  fir_sample_source_if.master bus
);

  localparam int           PW      = $clog2(PERIOD);
  localparam logic [PW-1:0] PH_READ = PW'(PERIOD - 2);
  localparam logic [PW-1:0] PH_LAST = PW'(PERIOD - 1);

  src_state_e    state;
  logic [PW-1:0] phase;
  logic [AW-1:0] addr;
  logic [AW:0]   len_l;
  logic          loop_l;
  logic          rd_en;
  logic          last;

  // Read at PH_READ so the word lands in the read register on the strobe cycle.
  // A stop in that cycle suppresses the read so xin does not move without en.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_en = 1'b0;
    if (state == RUN && phase == PH_READ && !bus.stop) begin
      rd_en = 1'b1;
    end
  end

  assign last = ({1'b0, addr} == len_l - (AW+1)'(1));

  fir_sample_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en),
    .rd_addr (addr),
    .rd_data (bus.xin)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= '0;
      addr     <= '0;
      len_l    <= '0;
      loop_l   <= 1'b0;
      bus.en   <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.en   <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state    <= RUN;
            bus.busy <= 1'b1;
            phase    <= '0;
            addr     <= '0;
            len_l    <= (AW+1)'(clamp_len(32'(bus.len), 32'(DEPTH)));
            loop_l   <= bus.loop;
          end
        end
        RUN: begin
          if (bus.stop) begin
            // An en already registered for this cycle still completes.
            state    <= IDLE;
            bus.busy <= 1'b0;
            phase    <= '0;
            addr     <= '0;
          end else begin
            phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
            if (phase == PH_READ) begin
              bus.en <= 1'b1;
            end
            // Strobe cycle: advance to the next table entry.
            if (phase == PH_LAST) begin
              if (!last) begin
                addr <= addr + AW'(1);
              end else if (loop_l) begin
                addr <= '0;
              end else begin
                state    <= IDLE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                phase    <= '0;
                addr     <= '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_source.sv
// Self-checking bench for fir_sample_source. A driver issues stimulus and
// pushes the strobes it expects into a queue; a monitor on the falling edge
// compares en/xin/busy/done against that queue and a shadow copy of the table.
module tb_fir_sample_source;

  localparam int DW     = 12;
  localparam int DEPTH  = 200;
  localparam int AW     = 8;
  localparam int PERIOD = 8;
  localparam int NEVER  = 1 << 30;

  typedef struct {
    int cyc;
    int addr;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fir_sample_source_if #(.DW(DW), .AW(AW)) bus ();

  fir_sample_source #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .PERIOD(PERIOD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  int  shadow [DEPTH];
  ev_t exp_q [$];
  int  bs = 0;          // first busy cycle
  int  be = 0;          // first cycle no longer busy
  int  done_c = -1;     // cycle with expected done pulse
  int  exp_xin = 0;
  int  pend_val = 0;
  bit  mon_on = 1'b0;
  bit  rst_prev = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit model_idle(input int t);
    return !(t >= bs && t < be);
  endfunction

  // Playback is cut short after cycle s (stop or reset sampled in cycle s).
  task automatic model_cut(input int s);
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > s) void'(exp_q.pop_back());
    if (done_c > s) done_c = -1;
    if (be > s + 1) be = s + 1;
  endtask

  task automatic model_start(input int t, input int ln, input bit lp);
    int n, cnt;
    n   = (ln == 0 || ln > DEPTH) ? DEPTH : ln;
    cnt = lp ? 64 : n;
    bs  = t + 1;
    for (int k = 1; k <= cnt; k++) exp_q.push_back('{cyc: t + PERIOD*k, addr: (k-1) % n});
    if (lp) begin
      be = NEVER;
      done_c = -1;
    end else begin
      be = t + PERIOD*n + 1;
      done_c = be;
    end
  endtask

  // Drive one clock of stimulus and update the model for that cycle.
  task automatic drive_cycle(input bit w, input int wa, input int wd,
                             input bit st, input bit sp, input int ln, input bit lp);
    int t;
    t = cyc;
    bus.wr_en   = w;
    bus.wr_addr = AW'(wa);
    bus.wr_data = DW'(wd);
    bus.start   = st;
    bus.stop    = sp;
    bus.len     = AW'(ln);
    bus.loop    = lp;
    if (sp && !model_idle(t)) model_cut(t);
    else if (st && !sp && model_idle(t)) model_start(t, ln, lp);
    @(posedge clk);
    #1;
    if (w && wa < DEPTH) shadow[wa] = wd;
    bus.wr_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) drive_cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    drive_cycle(1, a, d, 0, 0, 0, 0);
  endtask

  task automatic go(input int ln, input bit lp);
    drive_cycle(0, 0, 0, 1, 0, ln, lp);
  endtask

  task automatic halt();
    drive_cycle(0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic reset_cycles(input int n);
    repeat (n) begin
      rst = 1'b1;
      model_cut(cyc);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // Monitor: compares outputs every cycle on the falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      int c;
      bit exp_en;
      c = cyc;
      if (rst_prev) exp_xin = 0;
      exp_en = (exp_q.size() > 0 && exp_q[0].cyc == c);
      if (exp_en) begin
        exp_xin = pend_val;
        void'(exp_q.pop_front());
      end
      check("en",   int'(bus.en),   int'(exp_en));
      check("xin",  int'(bus.xin),  exp_xin);
      check("busy", int'(bus.busy), int'(c >= bs && c < be));
      check("done", int'(bus.done), int'(c == done_c));
      // Table word as seen by the read issued this cycle (read-first).
      if (exp_q.size() > 0 && exp_q[0].cyc == c + 1) pend_val = shadow[exp_q[0].addr];
      rst_prev = rst;
    end
  end

  initial begin
    int t;
    int ln, budget, stop_at, wa, wd;
    bit lp, w, sp, st;

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.len = '0; bus.loop = 1'b0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = 0;

    // Power-on reset: outputs must read as reset values while rst is sampled.
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    reset_cycles(2);

    // Fill the whole table with random words.
    for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(0, 4095)));

    // Single pass of three samples.
    wr(0, 'h100); wr(1, 'h200); wr(2, 'h300);
    go(3, 0);
    idle_cycles(30);

    // Looping two-entry table, with an ignored start while running.
    wr(0, 'h7FF); wr(1, 'h801);
    go(2, 1);
    idle_cycles(4);
    go(3, 0);
    idle_cycles(28);
    halt();
    idle_cycles(10);

    // Write to addr 1 in the very cycle it is read: old value first, new one next pass.
    go(2, 1);
    idle_cycles(14);
    wr(1, 'hABC);
    idle_cycles(20);
    halt();
    idle_cycles(10);

    // Stop mid-run at t+12, restart at t+20.
    wr(0, 'h100); wr(1, 'h200); wr(2, 'h300);
    t = cyc;
    go(3, 0);
    idle_cycles(11);
    halt();
    idle_cycles(7);
    go(3, 0);
    idle_cycles(30);

    // start and stop together in IDLE: stays idle.
    drive_cycle(0, 0, 0, 1, 1, 3, 0);
    idle_cycles(12);

    // Length clamp: len=0 plays the full table; write past the end is dropped.
    wr(DEPTH, 'h555);
    go(0, 0);
    idle_cycles(DEPTH*PERIOD + 6);

    // Randomised runs with concurrent writes, stops and stray starts.
    for (int r = 0; r < 14; r++) begin
      ln      = int'($urandom_range(1, 10));
      lp      = 1'($urandom_range(0, 1));
      budget  = ln*PERIOD + 12;
      stop_at = (lp || $urandom_range(0, 2) == 0) ? int'($urandom_range(3, ln*PERIOD + 4)) : -1;
      go(ln, lp);
      for (int i = 0; i < budget; i++) begin
        w  = ($urandom_range(0, 9) == 0);
        wa = int'($urandom_range(0, 209));
        wd = int'($urandom_range(0, 4095));
        sp = (i == stop_at);
        st = ($urandom_range(0, 15) == 0);
        drive_cycle(w, wa, wd, st, sp, ln, 1'b0);
      end
      idle_cycles(ln*PERIOD + 4);
    end

    // Reset in the middle of looping playback.
    go(5, 1);
    idle_cycles(20);
    reset_cycles(3);
    idle_cycles(24);

    check("pending_strobes", exp_q.size(), 0);
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
